i_fill_ctrl: RTL and testbench

//  Instruction-cache refill controller sitting directly upstream of i_cache.
//  On a cache miss it fetches the 16-word line containing the missing PC from instruction memory.
//  It accepts one 32-bit beat per valid cycle, assembles the line, then writes it into the cache in one cycle.
//  It stalls fetch from the miss until the line is written, and reports fills that fail or are out of range.

---
 rtl/i_fill_ctrl_pkg.sv | 31 +++
 rtl/i_fill_ctrl.sv | 154 +++++++++++++++
 tb/tb_i_fill_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i_fill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill path: memory window,
// line geometry, refill FSM states and small address helpers.
package tk_pkg;

   localparam int unsigned LINE_WORDS = 16;
   localparam int unsigned CNT_W      = $clog2(LINE_WORDS);
   localparam logic [31:0] IMEM_BASE  = 32'h0001_0000;
   localparam logic [31:0] IMEM_LIMIT = 32'h0001_01FF;
   localparam logic [31:0] LINE_MASK  = 32'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      RECV   = 3'd2,
      WRITE  = 3'd3,
      SETTLE = 3'd4
   } ifill_state_t;

   typedef logic [31:0] line_t [0:LINE_WORDS-1];

   // True when a word address falls inside instruction memory.
   function automatic logic pc_in_range(input logic [31:0] pc);
      return (pc >= IMEM_BASE) && (pc <= IMEM_LIMIT);
   endfunction

   // Base word address of the line containing pc.
   function automatic logic [31:0] line_base(input logic [31:0] pc);
      return pc & ~LINE_MASK;
   endfunction

endpackage

// File: rtl/i_fill_ctrl.sv
// Instruction-cache refill controller. On a miss it requests the whole line
// from instruction memory, collects the beats in order, writes the line into
// the cache in a single cycle, and holds fetch until the cache has settled.
module i_fill_ctrl
   import tk_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_miss,
   input  logic [31:0] miss_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_err,
   output line_t       wr_ins,
   output logic        wr_en,
   output logic [31:0] fill_addr,
   output logic        stall_fetch,
   output logic        fill_err
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

   ifill_state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      base_q, base_d;
   line_t            wr_ins_q, wr_ins_d;
   logic             mem_req_q, mem_req_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic             wr_en_q, wr_en_d;
   logic [31:0]      fill_addr_q, fill_addr_d;
   logic             fill_err_q, fill_err_d;

   // Next-state and next-output logic for the refill sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      wr_ins_d    = wr_ins_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      wr_en_d     = 1'b0;
      fill_addr_d = fill_addr_q;
      fill_err_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // Beats and errors arriving while idle belong to nobody.
            if (i_miss) begin
               if (pc_in_range(miss_pc)) begin
                  base_d     = line_base(miss_pc);
                  mem_addr_d = line_base(miss_pc);
                  mem_req_d  = 1'b1;
                  state_d    = REQ;
               end else begin
                  fill_err_d = 1'b1;
                  state_d    = IDLE;
               end
            end else begin
               state_d = IDLE;
            end
         end

         REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               cnt_d     = CNT_ZERO;
               state_d   = RECV;
            end else begin
               mem_req_d = 1'b1;
               state_d   = REQ;
            end
         end

         RECV: begin
            // An error outranks a beat presented in the same cycle.
            if (mem_err) begin
               fill_err_d = 1'b1;
               cnt_d      = CNT_ZERO;
               state_d    = IDLE;
            end else if (mem_rvalid) begin
               wr_ins_d[cnt_q] = mem_rdata;
               if (cnt_q == LAST_BEAT) begin
                  // The counter is parked at zero rather than allowed to wrap.
                  cnt_d       = CNT_ZERO;
                  wr_en_d     = 1'b1;
                  fill_addr_d = base_q;
                  state_d     = WRITE;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
                  state_d = RECV;
               end
            end else begin
               state_d = RECV;
            end
         end

         WRITE: begin
            // wr_en is high during this state only.
            state_d = SETTLE;
         end

         SETTLE: begin
            // Dead cycle so the cache valid bit is visible before the next miss.
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State, beat counter, line buffer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_ZERO;
         base_q      <= 32'd0;
         wr_ins_q    <= '{default: 32'd0};
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'd0;
         wr_en_q     <= 1'b0;
         fill_addr_q <= 32'd0;
         fill_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         wr_ins_q    <= wr_ins_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         wr_en_q     <= wr_en_d;
         fill_addr_q <= fill_addr_d;
         fill_err_q  <= fill_err_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign wr_ins      = wr_ins_q;
   assign wr_en       = wr_en_q;
   assign fill_addr   = fill_addr_q;
   assign fill_err    = fill_err_q;
   // Fetch must hold from the very cycle the miss appears, hence combinational.
   assign stall_fetch = i_miss | (state_q != IDLE);

endmodule

// File: tb/tb_i_fill_ctrl.sv
// Self-checking bench for i_fill_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level refill model.
module tb_i_fill_ctrl;
   import tk_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_miss = 1'b0;
   logic [31:0] miss_pc = 32'd0;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_err = 1'b0;
   logic        mem_req, wr_en, stall_fetch, fill_err;
   logic [31:0] mem_addr, fill_addr;
   line_t       wr_ins;

   i_fill_ctrl dut (
      .clk(clk), .rst_n(rst_n), .i_miss(i_miss), .miss_pc(miss_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .wr_ins(wr_ins), .wr_en(wr_en), .fill_addr(fill_addr),
      .stall_fetch(stall_fetch), .fill_err(fill_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;

   // ---------------- reference model (transaction level) ----------------
   logic [31:0] m_words [0:LINE_WORDS-1];
   logic [31:0] m_beats [$];
   bit          m_open, m_granted;
   int          m_tail;
   logic [31:0] m_base;
   bit          e_req, e_wr, e_err;
   logic [31:0] e_addr, e_fill;

   task automatic model_reset();
      for (int i = 0; i < LINE_WORDS; i++) m_words[i] = 32'd0;
      m_beats.delete();
      m_open = 1'b0; m_granted = 1'b0; m_tail = 0; m_base = 32'd0;
      e_req = 1'b0; e_wr = 1'b0; e_err = 1'b0; e_addr = 32'd0; e_fill = 32'd0;
   endtask

   // Outputs expected after a clock edge, given the inputs seen at that edge.
   task automatic model_step();
      e_err = 1'b0;
      e_wr  = 1'b0;
      if (m_tail > 0) begin
         m_tail--;                       // write cycle, then settle cycle
      end else if (!m_open) begin
         if (i_miss) begin
            if (miss_pc >= IMEM_BASE && miss_pc <= IMEM_LIMIT) begin
               m_open = 1'b1; m_granted = 1'b0;
               m_base = miss_pc - (miss_pc % 32'(LINE_WORDS));
               e_req = 1'b1; e_addr = m_base;
               m_beats.delete();
            end else begin
               e_err = 1'b1;
            end
         end
      end else if (!m_granted) begin
         if (mem_gnt) begin
            m_granted = 1'b1;
            e_req = 1'b0;
         end
      end else if (mem_err) begin
         e_err = 1'b1;
         m_open = 1'b0;
      end else if (mem_rvalid) begin
         m_words[m_beats.size()] = mem_rdata;
         m_beats.push_back(mem_rdata);
         if (m_beats.size() == LINE_WORDS) begin
            e_wr = 1'b1; e_fill = m_base;
            m_open = 1'b0; m_tail = 2;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock: step the model at the edge, return to the drive point.
   task automatic cyc();
      @(posedge clk);
      cyc_n++;
      if (!rst_n) model_reset();
      else model_step();
      #2;
   endtask

   // ---------------- per-cycle compare and event capture ----------------
   bit          mon_en = 1'b0;
   logic        prev_req = 1'b0;
   int          wr_seen = 0, req_rises = 0, req_cycles = 0;
   int          cap_cycle = 0, fill_t0 = 0;
   logic [31:0] cap_fill, cap_w0, cap_w15, cap_req_addr;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            int bad;
            bad = 0;
            chk("mem_req", 32'(mem_req), 32'(e_req));
            if (e_req) chk("mem_addr", mem_addr, e_addr);
            chk("wr_en", 32'(wr_en), 32'(e_wr));
            if (e_wr) chk("fill_addr", fill_addr, e_fill);
            chk("fill_err", 32'(fill_err), 32'(e_err));
            chk("stall_fetch", 32'(stall_fetch), 32'(i_miss | m_open | (m_tail > 0)));
            for (int i = LINE_WORDS - 1; i >= 0; i--)
               if (wr_ins[i] !== m_words[i]) bad = i;
            chk($sformatf("wr_ins[%0d]", bad), wr_ins[bad], m_words[bad]);
            if (wr_en) begin
               wr_seen++; cap_cycle = cyc_n; cap_fill = fill_addr;
               cap_w0 = wr_ins[0]; cap_w15 = wr_ins[LINE_WORDS-1];
            end
            if (mem_req) req_cycles++;
            if (mem_req && !prev_req) begin
               req_rises++; cap_req_addr = mem_addr;
            end
            prev_req = mem_req;
         end
      end
   end

   // One refill: miss, grant after gnt_dly cycles, beats with gap idle cycles
   // between them, optional error on beat err_beat, optional held i_miss.
   task automatic run_fill(input logic [31:0] pc, input int gnt_dly, input int gap,
                           input int err_beat, input bit hold, input logic [31:0] dbase);
      fill_t0 = cyc_n;
      i_miss = 1'b1; miss_pc = pc;
      cyc();
      if (!hold) i_miss = 1'b0;
      #3;
      chk("req_after_miss", 32'(mem_req), 32'd1);
      repeat (gnt_dly) cyc();
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      for (int b = 0; b < LINE_WORDS; b++) begin
         if (b > 0) repeat (gap) cyc();
         mem_rvalid = 1'b1; mem_rdata = dbase + 32'(b); mem_err = (b == err_beat);
         cyc();
         mem_rvalid = 1'b0; mem_err = 1'b0;
         if (b == err_beat) break;
      end
      if (err_beat < 0) begin
         cyc();
         cyc();
      end
      i_miss = 1'b0;
   endtask

   initial begin
      int w0, r0, c0;
      logic [31:0] d;
      model_reset();
      #3;
      // reset values
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_fill_err", 32'(fill_err), 32'd0);
      chk("rst_stall", 32'(stall_fetch), 32'd0);
      chk("rst_wr_ins0", wr_ins[0], 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      mon_en = 1'b1;
      cyc();

      // 2: aligned-down base, no gaps, wr_en 18 cycles after the miss
      w0 = wr_seen;
      run_fill(32'h0001_0013, 0, 0, -1, 1'b0, 32'hA0);
      chk("t2_req_addr", cap_req_addr, 32'h0001_0010);
      chk("t2_wr_count", 32'(wr_seen - w0), 32'd1);
      chk("t2_wr_cycle", 32'(cap_cycle - fill_t0), 32'd18);
      chk("t2_fill_addr", cap_fill, 32'h0001_0010);
      chk("t2_w0", cap_w0, 32'hA0);
      chk("t2_w15", cap_w15, 32'hAF);

      // 3: grant delayed 4 cycles, one idle cycle between beats
      w0 = wr_seen; c0 = req_cycles;
      run_fill(32'h0001_0013, 4, 1, -1, 1'b0, 32'hB0);
      chk("t3_req_cycles", 32'(req_cycles - c0), 32'd5);
      chk("t3_wr_count", 32'(wr_seen - w0), 32'd1);
      chk("t3_w0", cap_w0, 32'hB0);
      chk("t3_w15", cap_w15, 32'hBF);

      // 4: error on beat 7 aborts, next miss starts over
      w0 = wr_seen;
      run_fill(32'h0001_0105, 0, 0, 7, 1'b0, 32'hC0);
      #3;
      chk("t4_fill_err", 32'(fill_err), 32'd1);
      chk("t4_idle_stall", 32'(stall_fetch), 32'd0);
      cyc();
      chk("t4_no_write", 32'(wr_seen - w0), 32'd0);
      run_fill(32'h0001_0105, 1, 0, -1, 1'b0, 32'hD0);
      chk("t4_refill", 32'(wr_seen - w0), 32'd1);
      chk("t4_fill_addr", cap_fill, 32'h0001_0100);

      // 5: out-of-range miss
      r0 = req_rises;
      i_miss = 1'b1; miss_pc = 32'h0002_0000;
      #3;
      chk("t5_stall_miss", 32'(stall_fetch), 32'd1);
      cyc();
      i_miss = 1'b0;
      #3;
      chk("t5_fill_err", 32'(fill_err), 32'd1);
      chk("t5_no_req", 32'(mem_req), 32'd0);
      chk("t5_stall_idle", 32'(stall_fetch), 32'd0);
      cyc();
      #3;
      chk("t5_err_pulse", 32'(fill_err), 32'd0);
      cyc();
      chk("t5_no_rise", 32'(req_rises - r0), 32'd0);

      // 6: miss held through fill and settle gives one fill; idle beats ignored
      w0 = wr_seen; r0 = req_rises;
      run_fill(32'h0001_01FF, 2, 0, -1, 1'b1, 32'hE0);
      chk("t6_one_req", 32'(req_rises - r0), 32'd1);
      chk("t6_one_write", 32'(wr_seen - w0), 32'd1);
      chk("t6_fill_addr", cap_fill, 32'h0001_01F0);
      for (int k = 0; k < 4; k++) begin
         mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_err = 1'b1; mem_rdata = $urandom;
         cyc();
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_err = 1'b0;
      cyc();
      #3;
      chk("t6_keep_w0", wr_ins[0], 32'hE0);
      chk("t6_keep_w15", wr_ins[LINE_WORDS-1], 32'hEF);
      chk("t6_idle_req", 32'(mem_req), 32'd0);
      cyc();

      // 1: async reset after 5 beats discards the partial line
      i_miss = 1'b1; miss_pc = 32'h0001_0040;
      cyc();
      i_miss = 1'b0; mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0;
      for (int b = 0; b < 5; b++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'h5500 + 32'(b);
         cyc();
      end
      mem_rvalid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      i_miss = 1'b1;
      #1;
      chk("t1_stall_miss", 32'(stall_fetch), 32'd1);
      i_miss = 1'b0;
      #1;
      chk("t1_stall_nomiss", 32'(stall_fetch), 32'd0);
      chk("t1_req_drop", 32'(mem_req), 32'd0);
      chk("t1_wr_en", 32'(wr_en), 32'd0);
      chk("t1_line_clear", wr_ins[0], 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();
      w0 = wr_seen;
      run_fill(32'h0001_0040, 0, 0, -1, 1'b0, 32'h7700);
      chk("t1_refetch", 32'(wr_seen - w0), 32'd1);
      chk("t1_w0", cap_w0, 32'h7700);
      chk("t1_w15", cap_w15, 32'h770F);

      // randomized traffic
      w0 = wr_seen;
      for (int k = 0; k < 3000; k++) begin
         i_miss = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 9))
            0: miss_pc = 32'h0000_FFFF;
            1: miss_pc = 32'h0001_0200;
            2: miss_pc = $urandom;
            3: miss_pc = IMEM_LIMIT;
            default: miss_pc = IMEM_BASE + 32'($urandom_range(0, 511));
         endcase
         mem_gnt    = ($urandom_range(0, 2) == 0);
         mem_rvalid = ($urandom_range(0, 2) != 0);
         mem_rdata  = $urandom;
         mem_err    = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 799) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end else begin
            rst_n = 1'b1;
         end
         cyc();
      end
      rst_n = 1'b1; i_miss = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
      d = 32'(wr_seen - w0);
      chk("rand_fills_seen", 32'(d > 32'd0), 32'd1);
      cyc(); cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
